// File: rtl/ysyx_041461_ifreg_pkg.sv
// ysyx_041461_ifreg_pkg: shared encodings for the fetch PC register and its trap-redirect interface
// Contents: WB redirect kinds (CTRL_*), fetch sequencer states (state_t), mtvec mode values (MODE_*).
package ysyx_041461_ifreg_pkg;
    localparam logic [1:0] CTRL_NOP      = 2'b00;
    localparam logic [1:0] CTRL_MTVEC    = 2'b01;
    localparam logic [1:0] CTRL_MEPC     = 2'b10;
    localparam logic [1:0] MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MODE_VECTORED = 2'b01;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/ysyx_041461_trap_target.sv
// ysyx_041461_trap_target: combinational WB trap redirect target (mepc, or mtvec direct/vectored)
// Ports: i_ctrl redirect kind, i_mtvec/i_mepc CSR values, i_cause/i_is_intr trap info, o_target next PC.
module ysyx_041461_trap_target
    import ysyx_041461_ifreg_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_ctrl,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic [XLEN-2:0] i_cause,
    input  logic            i_is_intr,
    output logic [XLEN-1:0] o_target
);
    logic [XLEN-1:0] w_base;
    logic            w_vec;
    assign w_base   = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_vec    = i_mtvec[1:0] == MODE_VECTORED && i_is_intr;
    assign o_target = i_ctrl == CTRL_MEPC ? i_mepc : w_vec ? w_base + ({1'b0, i_cause} << 2) : w_base;
endmodule

// File: rtl/ysyx_041461_ifreg.sv
// ysyx_041461_ifreg: fetch PC register and single-outstanding fetch sequencer with trap/branch redirect
// Ports: clk/rst (async active-low); IFreg_ctrl/mtvec/mepc/CAUSE/is_intr WB trap redirect;
//        IFreg_br_valid/br_pc EXE redirect; IFreg_stall ID backpressure; IFreg_req_* fetch request;
//        IFreg_rsp_* fetch response; IFreg_out_* instruction to ID; IFreg_IF_ok bus idle; IFreg_flush kill pulse.
module ysyx_041461_ifreg
    import ysyx_041461_ifreg_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      IFreg_ctrl,
    input  logic [XLEN-1:0] IFreg_mtvec,
    input  logic [XLEN-1:0] IFreg_mepc,
    input  logic [XLEN-2:0] IFreg_CAUSE,
    input  logic            IFreg_is_intr,
    input  logic            IFreg_br_valid,
    input  logic [XLEN-1:0] IFreg_br_pc,
    input  logic            IFreg_stall,
    output logic            IFreg_req_valid,
    output logic [XLEN-1:0] IFreg_req_addr,
    input  logic            IFreg_req_ready,
    input  logic            IFreg_rsp_valid,
    input  logic [31:0]     IFreg_rsp_inst,
    output logic            IFreg_out_valid,
    output logic [XLEN-1:0] IFreg_out_pc,
    output logic [31:0]     IFreg_out_inst,
    output logic            IFreg_out_misalign,
    output logic            IFreg_IF_ok,
    output logic            IFreg_flush
);
    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend_valid;
    logic            r_drop;
    logic [31:0]     r_inst;
    logic            r_misalign;
    logic [XLEN-1:0] w_target;
    logic            w_if_ok;
    logic            w_take;
    logic            w_drop;
    logic            w_pend_valid;
    logic [XLEN-1:0] w_pend_pc;
    ysyx_041461_trap_target #(.XLEN(XLEN)) u_trap_target (
        .i_ctrl    (IFreg_ctrl),
        .i_mtvec   (IFreg_mtvec),
        .i_mepc    (IFreg_mepc),
        .i_cause   (IFreg_CAUSE),
        .i_is_intr (IFreg_is_intr),
        .o_target  (w_target)
    );
    assign w_if_ok = r_state == S_IDLE || r_state == S_HOLD;
    assign w_take  = IFreg_ctrl != CTRL_NOP && w_if_ok;
    // While a fetch is in flight, any redirect (including one landing with the response) poisons it.
    assign w_drop       = r_drop || IFreg_ctrl != CTRL_NOP || IFreg_br_valid;
    assign w_pend_valid = r_pend_valid || IFreg_br_valid;
    assign w_pend_pc    = IFreg_br_valid ? IFreg_br_pc : r_pend_pc;
    assign IFreg_IF_ok        = w_if_ok;
    assign IFreg_flush        = w_take;
    assign IFreg_req_valid    = r_state == S_REQ;
    assign IFreg_req_addr     = IFreg_req_valid ? r_pc : '0;
    assign IFreg_out_valid    = r_state == S_HOLD;
    assign IFreg_out_pc       = IFreg_out_valid ? r_pc : '0;
    assign IFreg_out_inst     = IFreg_out_valid ? r_inst : '0;
    assign IFreg_out_misalign = IFreg_out_valid && r_misalign;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_drop       <= 1'b0;
            r_inst       <= '0;
            r_misalign   <= 1'b0;
        end else if (w_take) begin
            r_state      <= S_IDLE;
            r_pc         <= w_target;
            r_pend_valid <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if (!w_if_ok) begin
                r_drop       <= w_drop;
                r_pend_valid <= w_pend_valid;
                r_pend_pc    <= w_pend_pc;
            end
            case (r_state)
                S_IDLE: begin
                    if (IFreg_br_valid) begin
                        r_pc <= IFreg_br_pc;
                    end else if (r_pc[1:0] != 2'b00) begin
                        r_state    <= S_HOLD;
                        r_inst     <= '0;
                        r_misalign <= 1'b1;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: r_state <= IFreg_req_ready ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (IFreg_rsp_valid && w_drop) begin
                        r_state      <= S_IDLE;
                        r_pc         <= w_pend_valid ? w_pend_pc : r_pc;
                        r_drop       <= 1'b0;
                        r_pend_valid <= 1'b0;
                    end else if (IFreg_rsp_valid) begin
                        r_state    <= S_HOLD;
                        r_inst     <= IFreg_rsp_inst;
                        r_misalign <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (IFreg_br_valid) begin
                        r_state <= S_IDLE;
                        r_pc    <= IFreg_br_pc;
                    end else if (!IFreg_stall) begin
                        r_state <= S_IDLE;
                        r_pc    <= r_pc + XLEN'(4);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_041461_ifreg.sv
// tb_ysyx_041461_ifreg: directed self-checking bench for the fetch PC register
module tb_ysyx_041461_ifreg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  IFreg_ctrl = 2'b00;
    logic [63:0] IFreg_mtvec = '0;
    logic [63:0] IFreg_mepc = '0;
    logic [62:0] IFreg_CAUSE = '0;
    logic        IFreg_is_intr = 1'b0;
    logic        IFreg_br_valid = 1'b0;
    logic [63:0] IFreg_br_pc = '0;
    logic        IFreg_stall = 1'b0;
    logic        IFreg_req_valid;
    logic [63:0] IFreg_req_addr;
    logic        IFreg_req_ready = 1'b0;
    logic        IFreg_rsp_valid = 1'b0;
    logic [31:0] IFreg_rsp_inst = '0;
    logic        IFreg_out_valid;
    logic [63:0] IFreg_out_pc;
    logic [31:0] IFreg_out_inst;
    logic        IFreg_out_misalign;
    logic        IFreg_IF_ok;
    logic        IFreg_flush;
    int          n_chk = 0;
    int          n_err = 0;
    ysyx_041461_ifreg dut (
        .clk                (clk),
        .rst                (rst),
        .IFreg_ctrl         (IFreg_ctrl),
        .IFreg_mtvec        (IFreg_mtvec),
        .IFreg_mepc         (IFreg_mepc),
        .IFreg_CAUSE        (IFreg_CAUSE),
        .IFreg_is_intr      (IFreg_is_intr),
        .IFreg_br_valid     (IFreg_br_valid),
        .IFreg_br_pc        (IFreg_br_pc),
        .IFreg_stall        (IFreg_stall),
        .IFreg_req_valid    (IFreg_req_valid),
        .IFreg_req_addr     (IFreg_req_addr),
        .IFreg_req_ready    (IFreg_req_ready),
        .IFreg_rsp_valid    (IFreg_rsp_valid),
        .IFreg_rsp_inst     (IFreg_rsp_inst),
        .IFreg_out_valid    (IFreg_out_valid),
        .IFreg_out_pc       (IFreg_out_pc),
        .IFreg_out_inst     (IFreg_out_inst),
        .IFreg_out_misalign (IFreg_out_misalign),
        .IFreg_IF_ok        (IFreg_IF_ok),
        .IFreg_flush        (IFreg_flush)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic wait_req(input string tag, input logic [63:0] addr);
        int n = 0;
        while (!IFreg_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_valid"}, 64'(IFreg_req_valid), 64'd1);
        check({tag, "_req_addr"}, IFreg_req_addr, addr);
    endtask
    task automatic serve(input logic [31:0] inst);
        tick();
        IFreg_rsp_valid = 1'b1;
        IFreg_rsp_inst  = inst;
        tick();
        IFreg_rsp_valid = 1'b0;
    endtask
    initial begin
        tick();
        tick();
        check("rst_if_ok", 64'(IFreg_IF_ok), 64'd1);
        check("rst_req_valid", 64'(IFreg_req_valid), 64'd0);
        check("rst_req_addr", IFreg_req_addr, 64'd0);
        check("rst_out_valid", 64'(IFreg_out_valid), 64'd0);
        check("rst_out_pc", IFreg_out_pc, 64'd0);
        check("rst_flush", 64'(IFreg_flush), 64'd0);
        IFreg_req_ready = 1'b1;
        rst = 1'b1;
        tick();
        wait_req("t1a", 64'h8000_0000);
        check("t1a_if_ok", 64'(IFreg_IF_ok), 64'd0);
        tick();
        tick();
        IFreg_rsp_valid = 1'b1;
        IFreg_rsp_inst  = 32'h0000_0013;
        tick();
        IFreg_rsp_valid = 1'b0;
        check("t1a_out_valid", 64'(IFreg_out_valid), 64'd1);
        check("t1a_out_pc", IFreg_out_pc, 64'h8000_0000);
        check("t1a_out_inst", 64'(IFreg_out_inst), 64'h13);
        check("t1a_if_ok_hold", 64'(IFreg_IF_ok), 64'd1);
        wait_req("t1b", 64'h8000_0004);
        serve(32'h0010_0093);
        check("t1b_out_pc", IFreg_out_pc, 64'h8000_0004);
        check("t1b_out_inst", 64'(IFreg_out_inst), 64'h0010_0093);
        wait_req("t2pre", 64'h8000_0008);
        IFreg_ctrl  = 2'b01;
        IFreg_mtvec = 64'h8000_1000;
        tick();
        check("t2_wait_if_ok", 64'(IFreg_IF_ok), 64'd0);
        check("t2_wait_req", 64'(IFreg_req_valid), 64'd0);
        check("t2_wait_flush", 64'(IFreg_flush), 64'd0);
        IFreg_rsp_valid = 1'b1;
        IFreg_rsp_inst  = 32'hdead_beef;
        tick();
        IFreg_rsp_valid = 1'b0;
        check("t2_drop_out_valid", 64'(IFreg_out_valid), 64'd0);
        check("t2_take_if_ok", 64'(IFreg_IF_ok), 64'd1);
        check("t2_take_flush", 64'(IFreg_flush), 64'd1);
        tick();
        IFreg_ctrl = 2'b00;
        #1;
        check("t2_flush_end", 64'(IFreg_flush), 64'd0);
        wait_req("t2", 64'h8000_1000);
        serve(32'h0000_0013);
        IFreg_stall = 1'b1;
        tick();
        check("t3_stall_valid", 64'(IFreg_out_valid), 64'd1);
        check("t3_stall_pc", IFreg_out_pc, 64'h8000_1000);
        IFreg_ctrl    = 2'b01;
        IFreg_mtvec   = 64'h8000_2001;
        IFreg_is_intr = 1'b1;
        IFreg_CAUSE   = 63'd7;
        #1;
        check("t3_flush", 64'(IFreg_flush), 64'd1);
        tick();
        IFreg_ctrl    = 2'b00;
        IFreg_is_intr = 1'b0;
        IFreg_stall   = 1'b0;
        check("t3_out_drop", 64'(IFreg_out_valid), 64'd0);
        wait_req("t3", 64'h8000_201C);
        IFreg_req_ready = 1'b0;
        IFreg_br_valid  = 1'b1;
        IFreg_br_pc     = 64'h8000_0080;
        tick();
        IFreg_br_pc = 64'h8000_0100;
        check("t4_hold_addr0", IFreg_req_addr, 64'h8000_201C);
        tick();
        IFreg_br_valid = 1'b0;
        check("t4_hold_addr1", IFreg_req_addr, 64'h8000_201C);
        tick();
        check("t4_hold_valid2", 64'(IFreg_req_valid), 64'd1);
        check("t4_hold_addr2", IFreg_req_addr, 64'h8000_201C);
        IFreg_req_ready = 1'b1;
        tick();
        check("t4_wait_req", 64'(IFreg_req_valid), 64'd0);
        IFreg_rsp_valid = 1'b1;
        IFreg_rsp_inst  = 32'h1234_5678;
        tick();
        IFreg_rsp_valid = 1'b0;
        check("t4_drop_out_valid", 64'(IFreg_out_valid), 64'd0);
        wait_req("t4", 64'h8000_0100);
        serve(32'h0000_0013);
        IFreg_stall    = 1'b1;
        IFreg_br_valid = 1'b1;
        IFreg_br_pc    = 64'h8000_0102;
        tick();
        IFreg_br_valid = 1'b0;
        tick();
        check("t5_req_valid", 64'(IFreg_req_valid), 64'd0);
        check("t5_out_valid", 64'(IFreg_out_valid), 64'd1);
        check("t5_misalign", 64'(IFreg_out_misalign), 64'd1);
        check("t5_out_inst", 64'(IFreg_out_inst), 64'd0);
        check("t5_out_pc", IFreg_out_pc, 64'h8000_0102);
        IFreg_ctrl = 2'b10;
        IFreg_mepc = 64'h8000_0200;
        #1;
        check("t5_mepc_flush", 64'(IFreg_flush), 64'd1);
        tick();
        IFreg_ctrl  = 2'b00;
        IFreg_stall = 1'b0;
        wait_req("t5", 64'h8000_0200);
        tick();
        check("t6_wait_if_ok", 64'(IFreg_IF_ok), 64'd0);
        rst = 1'b0;
        #1;
        check("t6_rst_if_ok", 64'(IFreg_IF_ok), 64'd1);
        check("t6_rst_req", 64'(IFreg_req_valid), 64'd0);
        tick();
        rst = 1'b1;
        IFreg_rsp_valid = 1'b1;
        IFreg_rsp_inst  = 32'hbad0_bad0;
        tick();
        IFreg_rsp_valid = 1'b0;
        check("t6_out_valid", 64'(IFreg_out_valid), 64'd0);
        wait_req("t6", 64'h8000_0000);
        serve(32'h0000_0013);
        IFreg_ctrl     = 2'b10;
        IFreg_mepc     = 64'h8000_0300;
        IFreg_br_valid = 1'b1;
        IFreg_br_pc    = 64'h8000_0400;
        tick();
        IFreg_ctrl     = 2'b00;
        IFreg_br_valid = 1'b0;
        wait_req("t7", 64'h8000_0300);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_041461_ifreg.md
Name: ysyx_041461_ifreg

Overview:
- PC register and fetch sequencer at the front of the 5-stage core; the consumer end of the trap-redirect interface the write-back stage drives.
- Holds the architectural fetch PC and issues single-outstanding instruction fetches on a valid/ready request plus response bus.
- Applies WB trap redirects (MTVEC/MEPC) and EXE branch redirects, drops fetches that are in flight when a redirect lands, and reports fetch-bus idle (IF_ok) back to WB.

Parameters:
RESET_PC, 64'h8000_0000, PC loaded at reset
XLEN, 64, PC/CSR width

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset (0 = reset)
IFreg_ctrl  in  2  WB redirect: NOP / MTVEC / MEPC (shared macro encodings)
IFreg_mtvec  in  64  current mtvec
IFreg_mepc  in  64  current mepc
IFreg_CAUSE  in  63  trap cause code
IFreg_is_intr  in  1  trap is an interrupt (enables vectored mode)
IFreg_br_valid  in  1  EXE branch/jump redirect
IFreg_br_pc  in  64  branch target
IFreg_stall  in  1  ID cannot accept an instruction this cycle
IFreg_req_valid  out  1  fetch request valid
IFreg_req_addr  out  64  fetch address
IFreg_req_ready  in  1  bus accepts request
IFreg_rsp_valid  in  1  fetch data returned
IFreg_rsp_inst  in  32  fetched instruction
IFreg_out_valid  out  1  instruction valid to ID
IFreg_out_pc  out  64  PC of out_inst
IFreg_out_inst  out  32  instruction (0 on misalign)
IFreg_out_misalign  out  1  fetch address misaligned (IF_MISALIGN trap)
IFreg_IF_ok  out  1  no bus transaction outstanding (drives WB_IF_ok)
IFreg_flush  out  1  one-cycle pulse: kill younger ID/EXE/MEM contents

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; state=IDLE; pending redirect cleared. All outputs are 0 except IF_ok=1.
- State machine:
  - IDLE: pc[1:0]!=0 -> go to HOLD with out_misalign=1, inst=0, and no bus request. Otherwise assert req -> REQ.
  - REQ: req_valid=1; req_addr=pc, held stable until req_ready. On handshake -> WAIT.
  - WAIT: on rsp_valid, latch inst. If the drop flag is set -> IDLE (discard response). Otherwise -> HOLD.
  - HOLD: out_valid=1. If !stall: pc<=pc+4 and go to IDLE, which re-requests next cycle (registered request, 1 bubble per instruction is accepted).
- IF_ok = (state==IDLE || state==HOLD). It is combinational and reflects the current state only.
- WB redirect:
  - Taken only in a cycle with IFreg_ctrl!=NOP && IF_ok==1; this is the cycle WB retires the trap.
  - Target for MEPC: mepc.
  - Target for MTVEC: if mtvec[1:0]==2'b01 && is_intr, target = {mtvec[63:2],2'b00} + (CAUSE<<2); otherwise {mtvec[63:2],2'b00}. Arithmetic is 64-bit, wraps mod 2^64.
  - On take: pc<=target; state<=IDLE; out_valid drops next cycle; flush=1 for that cycle.
  - While ctrl!=NOP and IF_ok==0: no new request is issued from IDLE. An already-asserted REQ still completes (valid is never withdrawn). The drop flag is set, and the response is discarded in WAIT.
- EXE branch (br_valid):
  - In IDLE or HOLD: pc<=br_pc, state<=IDLE.
  - In REQ or WAIT: br_pc is stored in a pending register and the drop flag is set. When the response arrives (discarded), pc<=pending and the pending register is cleared.
  - flush is not driven by this block for branches; EXE owns that.
- Simultaneous WB redirect and br_valid: WB wins and clears any pending branch.
- Branch arriving while a pending branch already exists: the newer one overwrites it.
- Reset mid-transaction: state returns to IDLE immediately. The bus ignores a lost response after reset; the block discards any rsp_valid seen in IDLE or HOLD.
- out_pc/out_inst/out_misalign hold stable while out_valid && stall.

Decomposition:
- Shared macro file holds: WB_IFreg_ctrl encodings (NOP/MTVEC/MEPC); state encodings IDLE/REQ/WAIT/HOLD; mtvec mode constants DIRECT=0, VECTORED=1.
- One natural sub-module: ysyx_041461_trap_target, a combinational mtvec/mepc target calculator.

Test Plan:
- Reset release, req_ready=1, rsp after 2 cycles with inst 0x00000013 -> req_addr 0x80000000, then 0x80000004; out_pc increments by 4.
- Redirect arrives while WAIT:
  - Stimulus: stall=0, ctrl=MTVEC, mtvec=0x80001000, fetch in WAIT.
  - Required: IF_ok=0 and no new req; response discarded; next cycle IF_ok=1, redirect taken, flush pulse, next req_addr 0x80001000.
- Vectored interrupt: mtvec=0x80002001, is_intr=1, CAUSE=7, ctrl=MTVEC in HOLD -> next req_addr 0x8000201C.
- Branch in REQ with req_ready=0 for 3 cycles, br_pc=0x80000100 -> req_addr stays at old pc until handshake; response dropped; next req 0x80000100.
- Misaligned pc: br_pc=0x80000102 -> no req_valid; out_valid=1, out_misalign=1, out_inst=0, out_pc=0x80000102.
- Assert rst=0 mid-WAIT, release -> req_addr=0x80000000; stale rsp_valid in IDLE is ignored.
